fwd_hazard_ctrl: RTL and testbench

- Control-side counterpart of the 32-bit 3:1 ALU operand muxes in the 5-stage pipeline.
- Tracks destination-register state of in-flight instructions in its own EX/MEM/WB shadow registers.
- Produces the two 2-bit operand selects, the load-use stall, and a saturating stall counter.
- Sits beside the ID/EX pipeline register and consumes decode-stage fields.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 19 +
 rtl/fwd_hazard_ctrl_sel.sv | 29 ++
 rtl/fwd_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding / load-use hazard controller:
// operand-mux select encoding and the in-flight stage record.
package fwd_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    // Select encoding must match the 3:1 operand mux wiring in the datapath.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;

endpackage

// File: rtl/fwd_hazard_ctrl_sel.sv
// Priority compare for one ALU operand: the EX/MEM producer beats the
// MEM/WB producer, and x0 never forwards.
module fwd_sel_unit #(
    parameter int REG_AW = 5
) (
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        sel
);
    import fwd_hazard_ctrl_pkg::*;

    always_comb begin
        sel = FWD_RF;
        if (ex_valid) begin
            if (mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
                sel = FWD_MEM;
            end else if (wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage pipeline.
// Keeps its own EX/MEM/WB shadow of destination-register state.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    import fwd_hazard_ctrl_pkg::*;

    stage_t             ex_q;
    stage_t             mem_q;
    logic [REG_AW-1:0]  ex_rs1_q;
    logic [REG_AW-1:0]  ex_rs2_q;
    logic               wb_valid_q;
    logic               wb_regwrite_q;
    logic [REG_AW-1:0]  wb_rd_q;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic hazard;
    logic issue;

    assign hazard = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid_i &&
                    ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
    // A flushed consumer never reaches EX, so it does not need the stall.
    assign stall_o = hazard && !flush_i;
    assign issue   = id_valid_i && !stall_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q          <= '0;
            mem_q         <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
        end else begin
            wb_valid_q    <= mem_q.valid;
            wb_regwrite_q <= mem_q.regwrite;
            wb_rd_q       <= mem_q.rd;
            mem_q         <= ex_q;
            if (issue) begin
                ex_q.valid    <= 1'b1;
                ex_q.rd       <= id_rd_i;
                ex_q.regwrite <= id_regwrite_i;
                ex_q.memread  <= id_memread_i;
                ex_rs1_q      <= id_rs1_i;
                ex_rs2_q      <= id_rs2_i;
            end else begin
                ex_q <= '0;
            end
        end
    end

    // Saturates at all-ones so a long-running counter never wraps to look small.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    fwd_sel_unit #(.REG_AW(REG_AW)) u_sel_a (
        .ex_valid     (ex_q.valid),
        .ex_rs        (ex_rs1_q),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .wb_valid     (wb_valid_q),
        .wb_regwrite  (wb_regwrite_q),
        .wb_rd        (wb_rd_q),
        .sel          (fwd_a_o)
    );

    fwd_sel_unit #(.REG_AW(REG_AW)) u_sel_b (
        .ex_valid     (ex_q.valid),
        .ex_rs        (ex_rs2_q),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.regwrite),
        .mem_rd       (mem_q.rd),
        .wb_valid     (wb_valid_q),
        .wb_regwrite  (wb_regwrite_q),
        .wb_rd        (wb_rd_q),
        .sel          (fwd_b_o)
    );

    // A load in MEM must never feed EX through the ALU-result path.
    a_no_sel11: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (fwd_a_o != 2'b11) && (fwd_b_o != 2'b11));
    a_no_load_fwd_mem: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(mem_q.valid && mem_q.memread && ((fwd_a_o == FWD_MEM) || (fwd_b_o == FWD_MEM))));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed instruction stream, expected
// selects/stall pushed per cycle, popped and compared by a separate monitor.
module tb_fwd_hazard_ctrl;

    localparam int REG_AW = 5;
    // Narrow counter so saturation is reachable in a few hundred cycles.
    localparam int CNT_W  = 8;

    localparam logic [1:0] RF  = 2'b00;
    localparam logic [1:0] WB  = 2'b01;
    localparam logic [1:0] MEM = 2'b10;

    typedef struct {
        logic [1:0]       a;
        logic [1:0]       b;
        logic             stall;
        logic [CNT_W-1:0] cnt;
        int               vec;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              flush_i;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               vec_no = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             rst_next = 1'b0;

    fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input int vec,
                                input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s vec=%0d actual=%0h required=%0h", name, vec, act, req);
        end
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("fwd_a",     e.vec, 16'(fwd_a_o),     16'(e.a));
                check_output("fwd_b",     e.vec, 16'(fwd_b_o),     16'(e.b));
                check_output("stall",     e.vec, 16'(stall_o),     16'(e.stall));
                check_output("stall_cnt", e.vec, 16'(stall_cnt_o), 16'(e.cnt));
            end
        end
    end

    // One ID-stage cycle; inputs change just after the edge, expectations describe that cycle.
    task automatic apply_stimulus(input logic v, input logic [REG_AW-1:0] rs1, rs2, rd,
                                  input logic rw, mr, fl,
                                  input logic [1:0] ea, eb, input logic es);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_n_i       = rst_next;
        id_valid_i    = v;
        id_rs1_i      = rs1;
        id_rs2_i      = rs2;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
        vec_no++;
        if (!rst_next) begin
            exp_cnt = '0;
            e = '{a: RF, b: RF, stall: 1'b0, cnt: '0, vec: vec_no};
        end else begin
            e = '{a: ea, b: eb, stall: es, cnt: exp_cnt, vec: vec_no};
            if (es && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic alu(input logic [REG_AW-1:0] rd, rs1, rs2,
                       input logic [1:0] ea, eb, input logic es);
        apply_stimulus(1'b1, rs1, rs2, rd, 1'b1, 1'b0, 1'b0, ea, eb, es);
    endtask

    task automatic load(input logic [REG_AW-1:0] rd, rs1,
                        input logic [1:0] ea, eb, input logic es);
        apply_stimulus(1'b1, rs1, 5'd0, rd, 1'b1, 1'b1, 1'b0, ea, eb, es);
    endtask

    task automatic bubble(input logic [1:0] ea, eb, input logic es);
        apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ea, eb, es);
    endtask

    initial begin
        rst_n_i = 1'b0; id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        id_regwrite_i = 1'b0; id_memread_i = 1'b0; flush_i = 1'b0;

        rst_next = 1'b0;
        bubble(RF, RF, 1'b0);
        bubble(RF, RF, 1'b0);
        rst_next = 1'b1;

        // EX/MEM forward: add x5 ; sub x6,x5,x7
        alu(5, 1, 2, RF, RF, 1'b0);
        alu(6, 5, 7, RF, RF, 1'b0);
        bubble(MEM, RF, 1'b0);
        bubble(RF, RF, 1'b0);

        // MEM/WB forward: add x5 ; nop ; or x8,x5,x5
        alu(5, 1, 2, RF, RF, 1'b0);
        bubble(RF, RF, 1'b0);
        alu(8, 5, 5, RF, RF, 1'b0);
        bubble(WB, WB, 1'b0);

        // Youngest producer wins: add x5 ; add x5 ; or x8,x5,x1
        alu(5, 1, 2, RF, RF, 1'b0);
        alu(5, 3, 4, RF, RF, 1'b0);
        alu(8, 5, 1, RF, RF, 1'b0);
        bubble(MEM, RF, 1'b0);
        bubble(RF, RF, 1'b0);

        // x0 guard for ALU producer and for a load
        alu(0, 1, 0, RF, RF, 1'b0);
        alu(9, 0, 0, RF, RF, 1'b0);
        bubble(RF, RF, 1'b0);
        bubble(RF, RF, 1'b0);
        load(0, 1, RF, RF, 1'b0);
        alu(9, 0, 0, RF, RF, 1'b0);
        bubble(RF, RF, 1'b0);

        // Load-use on rs1: lw x4 ; and x2,x4,x3 (held one cycle)
        load(4, 1, RF, RF, 1'b0);
        alu(2, 4, 3, RF, RF, 1'b1);
        alu(2, 4, 3, RF, RF, 1'b0);
        bubble(WB, RF, 1'b0);

        // Flush squashes the dependent: no stall, EX becomes a bubble
        load(4, 1, RF, RF, 1'b0);
        apply_stimulus(1'b1, 5'd4, 5'd3, 5'd2, 1'b1, 1'b0, 1'b1, RF, RF, 1'b0);
        bubble(RF, RF, 1'b0);

        // Load-use on rs2: lw x7 ; add x3,x1,x7
        load(7, 2, RF, RF, 1'b0);
        alu(3, 1, 7, RF, RF, 1'b1);
        alu(3, 1, 7, RF, RF, 1'b0);
        bubble(RF, WB, 1'b0);

        // Invalid ID slot never stalls
        load(4, 1, RF, RF, 1'b0);
        apply_stimulus(1'b0, 5'd4, 5'd4, 5'd2, 1'b1, 1'b0, 1'b0, RF, RF, 1'b0);
        bubble(RF, RF, 1'b0);

        // Repeated hazards drive the counter into saturation
        for (int i = 0; i < 260; i++) begin
            load(4, 1, RF, RF, 1'b0);
            alu(2, 4, 3, RF, RF, 1'b1);
        end
        bubble(RF, RF, 1'b0);

        // Asynchronous reset while a load sits in EX with a dependent in ID
        alu(5, 1, 2, RF, RF, 1'b0);
        load(4, 1, RF, RF, 1'b0);
        rst_next = 1'b0;
        alu(2, 4, 3, RF, RF, 1'b1);
        alu(2, 4, 3, RF, RF, 1'b1);
        rst_next = 1'b1;
        alu(8, 5, 5, RF, RF, 1'b0);
        alu(6, 8, 5, RF, RF, 1'b0);
        bubble(MEM, RF, 1'b0);
        bubble(RF, RF, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk_i);
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
